// File: rtl/blvds_transmitter.sv
// Frame-building serializer for the 18-bit BLVDS link: wraps FIFO samples into framed packets with checksums.
// Latency: one registered link word per clock; FH1 appears the cycle after iSTART is accepted.
// Backpressure: waits (sending fill) until a whole packet is in the FIFO, then streams it without gaps.
//
// Ports:
//   iCLK, iRST                : clock, asynchronous active-high reset
//   iSTART + iFORMAT..iSAMPLE_NUM : frame request and frame parameters (latched on accept)
//   iRD_DATA/iRD_EMPTY/iRD_USEDW, oRD_REQ : show-ahead FIFO read side
//   oDATA_BLVDS               : registered 18-bit link word
//   oREADY/oBUSY/oDONE/oUNDERFLOW : status
module blvds_transmitter #(
  parameter logic [7:0] IDLE_WORDS = 8'd128
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [2:0]  iFORMAT,
  input  logic [7:0]  iPACK_NUM,
  input  logic [3:0]  iCHANNELS,
  input  logic [7:0]  iPACK_SIZE,
  input  logic [15:0] iSAMPLE_NUM,
  input  logic [15:0] iRD_DATA,
  input  logic        iRD_EMPTY,
  input  logic [15:0] iRD_USEDW,
  output logic        oRD_REQ,
  output logic [17:0] oDATA_BLVDS,
  output logic        oREADY,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oUNDERFLOW
);

  localparam logic [17:0] SYNC_WORD = 18'h3FE00;
  localparam logic [17:0] FILL_WORD = 18'h00000;

  // The state names the word currently on oDATA_BLVDS.
  typedef enum logic [3:0] {
    S_IDLE, S_FH1, S_FH2, S_WAIT, S_PH1, S_PH2, S_DATA, S_PE1, S_PE2, S_FE1, S_FE2
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [17:0] nxt_word;

  logic [2:0]  format_q;
  logic [7:0]  pack_num_q;
  logic [3:0]  channels_q;
  logic [7:0]  pack_size_q;
  logic [15:0] sample_num_q;

  logic [1:0]  frame_cnt;
  logic [4:0]  pack_cnt;   // wrapping packet number carried in PH1
  logic [7:0]  pack_done;  // packets completed in this frame
  logic [16:0] word_cnt;   // data words sent in this packet, including the current one
  logic [15:0] pcrc;
  logic [17:0] fcrc;
  logic [7:0]  gap;

  logic        start_acc;
  logic [16:0] pkt_len;
  logic        fifo_ok;
  logic [7:0]  gap_inc;

  assign pkt_len   = {1'b0, sample_num_q} + 17'd8;
  assign fifo_ok   = ({1'b0, iRD_USEDW} >= pkt_len);
  assign start_acc = iSTART && oREADY && (state == S_IDLE);
  assign gap_inc   = (gap >= IDLE_WORDS) ? gap : gap + 8'd1;

  // Next state and the word that will be registered onto the link at the next edge.
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE: if (start_acc) nxt_state = S_FH1;
      S_FH1:  nxt_state = S_FH2;
      S_FH2,
      S_WAIT: nxt_state = fifo_ok ? S_PH1 : S_WAIT;
      S_PH1:  nxt_state = S_PH2;
      S_PH2:  nxt_state = S_DATA;
      S_DATA: nxt_state = (word_cnt == pkt_len) ? S_PE1 : S_DATA;
      S_PE1:  nxt_state = S_PE2;
      // The last packet goes straight to the frame epilog; no fill in between.
      S_PE2:  nxt_state = (pack_done == pack_num_q) ? S_FE1 :
                          (fifo_ok ? S_PH1 : S_WAIT);
      S_FE1:  nxt_state = S_FE2;
      S_FE2:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase

    nxt_word = SYNC_WORD;
    case (nxt_state)
      S_IDLE: nxt_word = SYNC_WORD;
      // FH1 is only entered from IDLE, so the live inputs are the frame parameters.
      S_FH1:  nxt_word = {2'b11, 3'b000, iFORMAT, frame_cnt, iPACK_NUM};
      S_FH2:  nxt_word = {2'b11, 3'b001, 1'b0, channels_q, pack_size_q};
      S_WAIT: nxt_word = FILL_WORD;
      S_PH1:  nxt_word = {2'b11, 3'b010, pack_cnt, sample_num_q[15:8]};
      S_PH2:  nxt_word = {2'b11, 3'b011, 5'd0, sample_num_q[7:0]};
      S_DATA: nxt_word = iRD_EMPTY ? FILL_WORD : {2'b00, iRD_DATA};
      S_PE1:  nxt_word = {2'b11, 3'b110, 5'd0, ~pcrc[15:8]};
      S_PE2:  nxt_word = {2'b11, 3'b111, 5'd0, ~pcrc[7:0]};
      S_FE1:  nxt_word = {2'b11, 3'b100, 5'd0, ~fcrc[15:8]};
      S_FE2:  nxt_word = {2'b11, 3'b101, 5'd0, ~fcrc[7:0]};
      default: nxt_word = SYNC_WORD;
    endcase
  end

  // Pop on the same edge that registers the data word.
  assign oRD_REQ = (nxt_state == S_DATA) && !iRD_EMPTY;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state        <= S_IDLE;
      oDATA_BLVDS  <= SYNC_WORD;
      oREADY       <= 1'b0;
      oBUSY        <= 1'b0;
      oDONE        <= 1'b0;
      oUNDERFLOW   <= 1'b0;
      format_q     <= '0;
      pack_num_q   <= '0;
      channels_q   <= '0;
      pack_size_q  <= '0;
      sample_num_q <= '0;
      frame_cnt    <= '0;
      pack_cnt     <= '0;
      pack_done    <= '0;
      word_cnt     <= '0;
      pcrc         <= '0;
      fcrc         <= '0;
      gap          <= '0;
    end else begin
      state       <= nxt_state;
      oDATA_BLVDS <= nxt_word;
      oDONE       <= 1'b0;

      if (state == S_IDLE) begin
        if (start_acc) begin
          format_q     <= iFORMAT;
          pack_num_q   <= iPACK_NUM;
          channels_q   <= iCHANNELS;
          pack_size_q  <= iPACK_SIZE;
          sample_num_q <= iSAMPLE_NUM;
          oREADY       <= 1'b0;
          oBUSY        <= 1'b1;
          oUNDERFLOW   <= 1'b0;
          pack_cnt     <= '0;
          pack_done    <= '0;
          pcrc         <= '0;
        end else begin
          gap    <= gap_inc;
          oREADY <= (gap_inc >= IDLE_WORDS);
        end
      end

      if (state == S_FE2) begin
        oDONE <= 1'b1;
        oBUSY <= 1'b0;
        gap   <= '0;
      end

      // Frame checksum covers every non-fill word from FH1 through the last PE2.
      case (nxt_state)
        S_FH1:  fcrc <= nxt_word;
        S_FH2, S_PH1, S_PH2, S_DATA, S_PE1, S_PE2: fcrc <= fcrc + nxt_word;
        default: ;
      endcase

      if (nxt_state == S_PH1)
        pcrc <= '0;

      if (nxt_state == S_DATA) begin
        // Underflow words are zero, so adding the sent word keeps the sum consistent.
        pcrc     <= pcrc + nxt_word[15:0];
        word_cnt <= (state == S_PH2) ? 17'd1 : word_cnt + 17'd1;
        if (iRD_EMPTY)
          oUNDERFLOW <= 1'b1;
      end

      if (nxt_state == S_PE2) begin
        pack_cnt  <= pack_cnt + 5'd1;
        pack_done <= pack_done + 8'd1;
      end

      if (nxt_state == S_FE2)
        frame_cnt <= frame_cnt + 2'd1;
    end
  end

endmodule

// File: doc/blvds_transmitter.md
# blvds_transmitter

Frame-building serializer for the 18-bit BLVDS link; the transmit end of the link protocol. It drains a show-ahead sample FIFO, wraps the samples into frame/packet header and epilog service words with packet and frame checksums, and drives one 18-bit word per clock onto the link. Between frames it sends the sync/idle word so the far end can realign.

## Interface
- IDLE_WORDS, 8'd128, minimum number of sync words sent between frames and after reset; must exceed the receiver frame latency.
- iCLK  in  1  clock; one link word per cycle.
- iRST  in  1  reset, asynchronous, active-high.
- iSTART  in  1  frame start request; sampled only while oREADY=1.
- iFORMAT  in  3  frame format field.
- iPACK_NUM  in  8  packets per frame; legal range 1..255.
- iCHANNELS  in  4  channel field.
- iPACK_SIZE  in  8  pack-size/mode field.
- iSAMPLE_NUM  in  16  sample-number field S; each packet carries S+8 data words; legal range S ≤ 16'hFFF7.
- iRD_DATA  in  16  show-ahead FIFO head word.
- iRD_EMPTY  in  1  FIFO empty.
- iRD_USEDW  in  16  FIFO fill level.
- oRD_REQ  out  1  FIFO read acknowledge (pop).
- oDATA_BLVDS  out  18  link word, registered.
- oREADY  out  1  idle gap complete; a frame can start.
- oBUSY  out  1  frame in progress.
- oDONE  out  1  one-cycle pulse after the last frame word is sent.
- oUNDERFLOW  out  1  sticky; set if the FIFO is empty during a data word; cleared by iSTART.

## Operation
- Service word layout: {2'b11, type[2:0], payload[12:0]}. Data word layout: {2'b00, sample[15:0]}. Fill word: 18'h00000. Sync word: 18'h3FE00.
- The parameter inputs are latched when iSTART is accepted and are held for the whole frame.
- State sequence: IDLE → FH1 → FH2 → WAIT → PH1 → PH2 → DATA → PE1 → PE2 → (WAIT if more packets, else FE1) → FE2 → IDLE.
- IDLE:
  - sends sync every cycle and counts the gap up to IDLE_WORDS, saturating.
  - oREADY = (gap ≥ IDLE_WORDS).
  - iSTART with oREADY=1 clears the CRCs, clears the packet counter, sets oBUSY, and moves to FH1.
- Service words:
  - FH1: type 000, [12:10]=iFORMAT, [9:8]=frame counter, [7:0]=iPACK_NUM.
  - FH2: type 001, [12]=0, [11:8]=iCHANNELS, [7:0]=iPACK_SIZE.
  - PH1: type 010, [12:8]=packet counter, [7:0]=S[15:8].
  - PH2: type 011, [12:8]=0, [7:0]=S[7:0].
  - PE1/PE2: types 110/111, [12:8]=0, [7:0]=~PCRC[15:8] / ~PCRC[7:0].
  - FE1/FE2: types 100/101, [12:8]=0, [7:0]=~FCRC[15:8] / ~FCRC[7:0].
- The frame counter is 2 bits and increments at FE2, wrapping 3→0. The packet counter is 5 bits, increments at PE2, and wraps 31→0.
- WAIT:
  - sends fill words until {1'b0, iRD_USEDW} ≥ S+8 (17-bit compare).
  - then moves to PH1.
  - Once PH1 is sent, the packet streams without gaps. Fill is never sent between PE2 of the last packet and FE1.
- DATA:
  - sends S+8 words; each word asserts oRD_REQ and outputs {2'b00, iRD_DATA}.
  - If iRD_EMPTY=1, the word sent is 18'h00000, oRD_REQ=0 and oUNDERFLOW is set. The word count still advances.
- PCRC: 16-bit wrapping sum of the packet's data samples; cleared at PH1.
- FCRC: 18-bit wrapping sum of every 18-bit word sent from FH1 through the last PE2, including the data words and the PE words. Fill words are excluded. FE words carry the complement of its low 16 bits.
- Sync is never sent inside a frame, because it resets the receiver's service counter.

## Timing
- Reset values:
  - oDATA_BLVDS=18'h3FE00.
  - oRD_REQ, oREADY, oBUSY, oDONE, oUNDERFLOW = 0.
  - state IDLE; gap, CRCs and counters = 0.
- iRST mid-frame aborts immediately; sync resumes on the next cycle.
- iSTART accepted in cycle n: FH1 appears on oDATA_BLVDS from cycle n+1; oREADY drops and oBUSY rises in cycle n+1.
- Frame length without fill: 4 + P·(S+12) words.
- oRD_REQ is combinationally aligned with the cycle that registers the data word. The FIFO pops on the same edge that loads oDATA_BLVDS.
- oDONE is high in the cycle after FE2 is sent, i.e. the first sync cycle. oBUSY falls in that same cycle. The gap count restarts at 0.
- iSTART while oREADY=0 is ignored (not queued).

## Test plan
- Single frame, P=1, S=0, all other fields 0, FIFO preloaded with 8×16'h0001:
  - sequence 30001, 32000, 34000, 36000, 8×00001, 3C0FF, 3E0F7, 3809E, 3A000 (hex).
  - oDONE is then pulsed and sync resumes.
- Reset release: exactly 128 sync words before oREADY=1; iSTART asserted at gap 127 is ignored.
- P=3, S=4, FIFO filled only to 11 words before PH1:
  - fill words continue until usedw=12, then the packet streams contiguously.
  - packet counter fields are 0, 1, 2.
  - FE carries the recomputed complement sum.
- Five back-to-back frames: frame counter field is 0, 1, 2, 3, 0; exactly 128 sync words separate the frames.
- FIFO empty forced mid-DATA for 2 cycles: two 18'h00000 data words are sent, oUNDERFLOW sets, and the frame length is unchanged.
- iRST asserted during DATA: the next word is 3FE00, oBUSY=0, and the next frame's FH1 shows frame counter 0.
